inst_fetch_queue: RTL and testbench

- Front-end stage directly upstream of the combinational instruction decoder.
- Generates fetch PCs and requests 32-bit instruction words from the memory controller, one outstanding request at a time.
- Buffers fetched words with their PCs in a circular FIFO; the decoder/issue stage pops from its head.
- Redirects statically on JAL and supports a full flush with a new PC on mispredict or exception.

---
 rtl/inst_fetch_queue.sv | 188 ++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Instruction fetch front end. Issues one 32-bit fetch at a
//               time to the memory controller. Buffers returned words with
//               their PCs in a circular FIFO that the decoder pops from.
//               Redirects statically on JAL. A flush restarts fetch at a new
//               PC and empties the queue.
// Ports       : clk, rst_n            - clock, async active-low reset
//               fetch_req/fetch_addr  - registered memory request (held
//                                       until fetch_done)
//               fetch_done/fetch_inst - one-cycle completion + data
//               iq_valid/iq_inst/
//               iq_pc/iq_pred_taken   - head of queue (combinational)
//               iq_pop                - consume head
//               flush/flush_pc        - discard queue, restart at flush_pc
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          QUEUE_DEPTH = 16,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    input  logic        iq_pop,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int                 c_PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic               w_req_nxt;
    logic [31:0]        w_addr_nxt;
    logic               w_push;
    logic               w_pop;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W:0]   r_count;  // one extra bit separates full from empty

    logic [31:0]        r_inst_mem [QUEUE_DEPTH];
    logic [31:0]        r_pc_mem   [QUEUE_DEPTH];
    logic               r_jal_mem  [QUEUE_DEPTH];

    // Static JAL target: J-type immediate, sign-extended from bit 20.
    logic               w_is_jal;
    logic [31:0]        w_jal_imm;
    logic [31:0]        w_next_pc;

    assign w_is_jal  = (fetch_inst[6:0] == 7'h6f);
    assign w_jal_imm = {{11{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                        fetch_inst[20], fetch_inst[30:21], 1'b0};
    assign w_next_pc = fetch_addr + (w_is_jal ? w_jal_imm : 32'd4);

    // ------------------------------------------------------------------------
    // FSM next-state and registered request values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = fetch_req;
        w_addr_nxt  = fetch_addr;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_pc_nxt = flush_pc;
                end else if (r_count < c_FULL) begin
                    // Space is reserved here, so the later push cannot overflow.
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_pc_nxt = flush_pc;
                    if (fetch_done) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Controller still owns the transaction; keep the
                        // request asserted and swallow its data later.
                        w_state_nxt = S_DRAIN;
                    end
                end else if (fetch_done) begin
                    w_push      = 1'b1;
                    w_pc_nxt    = w_next_pc;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    w_pc_nxt = flush_pc;
                end
                if (fetch_done) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            fetch_req  <= 1'b0;
            fetch_addr <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            fetch_req  <= w_req_nxt;
            fetch_addr <= w_addr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Circular queue; flush overrides both push and pop
    // ------------------------------------------------------------------------
    assign w_pop = iq_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_inst_mem[i] <= 32'h0;
                r_pc_mem[i]   <= 32'h0;
                r_jal_mem[i]  <= 1'b0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_inst_mem[r_tail] <= fetch_inst;
                r_pc_mem[r_tail]   <= fetch_addr;
                r_jal_mem[r_tail]  <= w_is_jal;
                r_tail             <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Head fields are masked when empty so stale slots never leak out.
    assign iq_valid      = (r_count != '0);
    assign iq_inst       = iq_valid ? r_inst_mem[r_head] : 32'h0;
    assign iq_pc         = iq_valid ? r_pc_mem[r_head]   : 32'h0;
    assign iq_pred_taken = iq_valid ? r_jal_mem[r_head]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_inst;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic        iq_pop;
    logic        flush;
    logic [31:0] flush_pc;

    int total = 0;
    int bad   = 0;

    inst_fetch_queue #(.QUEUE_DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_done   (fetch_done),
        .fetch_inst   (fetch_inst),
        .iq_valid     (iq_valid),
        .iq_inst      (iq_inst),
        .iq_pc        (iq_pc),
        .iq_pred_taken(iq_pred_taken),
        .iq_pop       (iq_pop),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a request and check its address.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'b0, fetch_req}, 32'h1);
        chk({tag, "_addr"}, fetch_addr, exp_addr);
    endtask

    // Serve one request with a single-cycle fetch_done pulse.
    task automatic do_fetch(input string tag, input logic [31:0] inst, input logic [31:0] exp_addr);
        wait_req(tag, exp_addr);
        fetch_done = 1'b1;
        fetch_inst = inst;
        @(negedge clk);
        fetch_done = 1'b0;
    endtask

    initial begin
        fetch_done = 1'b0;
        fetch_inst = 32'h0;
        iq_pop     = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        rst_n      = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_req",   {31'b0, fetch_req}, 32'h0);
        chk("rst_addr",  fetch_addr, 32'h0);
        chk("rst_valid", {31'b0, iq_valid}, 32'h0);
        chk("rst_inst",  iq_inst, 32'h0);
        chk("rst_pc",    iq_pc, 32'h0);
        chk("rst_pred",  {31'b0, iq_pred_taken}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- stream ----------------
        do_fetch("s0", 32'h00000013, 32'h0);
        chk("s0_valid", {31'b0, iq_valid}, 32'h1);
        chk("s0_inst",  iq_inst, 32'h00000013);
        chk("s0_pred",  {31'b0, iq_pred_taken}, 32'h0);
        do_fetch("s1", 32'h00000013, 32'h4);
        do_fetch("s2", 32'h00000013, 32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("s_pop_pc", iq_pc, 32'(4 * i));
            iq_pop = 1'b1;
            @(negedge clk);
        end
        chk("s_empty", {31'b0, iq_valid}, 32'h0);
        // pop on empty is ignored while a push lands
        wait_req("s3", 32'hc);
        fetch_done = 1'b1;
        fetch_inst = 32'h00000013;
        @(negedge clk);
        fetch_done = 1'b0;
        iq_pop     = 1'b0;
        chk("s3_valid", {31'b0, iq_valid}, 32'h1);
        chk("s3_pc",    iq_pc, 32'hc);
        // push while popping the only entry
        wait_req("s4", 32'h10);
        fetch_done = 1'b1;
        iq_pop     = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0;
        iq_pop     = 1'b0;
        chk("s4_valid", {31'b0, iq_valid}, 32'h1);
        chk("s4_pc",    iq_pc, 32'h10);

        // ---------------- fill ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_fetch("fill", 32'h00000013, 32'(4 * i));
        end
        repeat (5) @(negedge clk);
        chk("full_noreq", {31'b0, fetch_req}, 32'h0);
        chk("full_head",  iq_pc, 32'h0);
        iq_pop = 1'b1;
        @(negedge clk);
        iq_pop = 1'b0;
        chk("full_head1", iq_pc, 32'h4);
        chk("full_req_late", {31'b0, fetch_req}, 32'h0);
        @(negedge clk);
        chk("full_req", {31'b0, fetch_req}, 32'h1);
        chk("full_addr", fetch_addr, 32'h40);

        // ---------------- JAL forward / backward ----------------
        do_reset();
        do_fetch("j0", 32'h0100006f, 32'h0);
        chk("j0_pred", {31'b0, iq_pred_taken}, 32'h1);
        chk("j0_pc",   iq_pc, 32'h0);
        do_fetch("j1", 32'h0100006f, 32'h10);
        do_fetch("j2", 32'hffdff06f, 32'h20);
        wait_req("j3", 32'h1c);

        // ---------------- flush mid-request ----------------
        do_reset();
        do_fetch("f0", 32'h00000013, 32'h0);
        do_fetch("f1", 32'h00000013, 32'h4);
        do_fetch("f2", 32'h00000013, 32'h8);
        wait_req("f3", 32'hc);
        flush    = 1'b1;
        flush_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", {31'b0, iq_valid}, 32'h0);
        chk("fl_hold_req", {31'b0, fetch_req}, 32'h1);
        chk("fl_hold_addr", fetch_addr, 32'hc);
        @(negedge clk);
        chk("fl_hold_req2", {31'b0, fetch_req}, 32'h1);
        fetch_done = 1'b1;
        fetch_inst = 32'h0100006f;
        @(negedge clk);
        fetch_done = 1'b0;
        chk("fl_discard", {31'b0, iq_valid}, 32'h0);
        do_fetch("fl_new", 32'h00000013, 32'h100);
        chk("fl_new_valid", {31'b0, iq_valid}, 32'h1);
        chk("fl_new_pc", iq_pc, 32'h100);

        // ---------------- flush + done + pop together ----------------
        wait_req("sim", 32'h104);
        flush      = 1'b1;
        flush_pc   = 32'h200;
        fetch_done = 1'b1;
        fetch_inst = 32'h00000013;
        iq_pop     = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        fetch_done = 1'b0;
        iq_pop     = 1'b0;
        chk("sim_valid", {31'b0, iq_valid}, 32'h0);
        chk("sim_req",   {31'b0, fetch_req}, 32'h0);
        do_fetch("sim_new", 32'h00000013, 32'h200);
        chk("sim_new_pc", iq_pc, 32'h200);

        // ---------------- async reset mid-WAIT ----------------
        wait_req("ar", 32'h204);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   {31'b0, fetch_req}, 32'h0);
        chk("ar_valid", {31'b0, iq_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch("ar_resume", 32'h00000013, 32'h0);
        chk("ar_pc", iq_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
